// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder controller:
// nibble width, FSM state encoding and a nibble-count helper.
package adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int w);
    return w / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences a WIDTH-bit add through an external 4-bit adder,
// one nibble per cycle LSB first, with valid/ready on both sides.
module nibble_serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [NIB_W-1:0] add_a,
  output logic [NIB_W-1:0] add_b,
  output logic             add_cin,
  input  logic [NIB_W-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NUM_NIB = nib_count(WIDTH);
  localparam int IDX_W = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4, >= 4");
  end

  state_t           state;
  state_t           next;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             accept;
  logic             last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == LAST);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // next state, handshakes and adder drive
  always_comb begin
    next      = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next = RUN;
      end
      RUN: begin
        add_a   = a_reg[NIB_W*idx +: NIB_W];
        add_b   = b_reg[NIB_W*idx +: NIB_W];
        add_cin = carry_reg;
        if (last) next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // operand capture, nibble accumulation and carry chaining
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      carry_reg <= in_cin;
      a_reg     <= in_a;
      b_reg     <= in_b;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (state == RUN) begin
      out_sum[NIB_W*idx +: NIB_W] <= add_sum;
      carry_reg <= add_cout;
      if (last) out_cout <= add_cout;
      else      idx      <= idx + 1'b1;
    end
  end

endmodule
